// File: rtl/dec_scan_nx2n.sv
// N-to-2^N one-hot decoder with registered complementary outputs, active-low
// enable and a SCAN mode that sweeps the code with a programmable dwell.
module dec_scan_nx2n #(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_n,
  input  logic              mode,
  input  logic [N-1:0]      in,
  input  logic [DW-1:0]     dwell,
  output logic [(1<<N)-1:0] y,
  output logic [(1<<N)-1:0] y_n,
  output logic [N-1:0]      code,
  output logic              wrap
);

  localparam int W = 1 << N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    y_q, y_d;
  logic [W-1:0]    y_n_q, y_n_d;
  logic [N-1:0]    code_q, code_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            wrap_q, wrap_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      y_n_q   <= '1;
      code_q  <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      y_n_q   <= y_n_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  // The enable is tested before in is looked at, so X on in while disabled
  // never reaches the registers.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    y_d     = '0;

    if (en_n) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d = DIRECT;
      code_d  = in;
      y_d     = {{(W-1){1'b0}}, 1'b1} << in;
    end else begin
      state_d = SCAN;
      if (state_q != SCAN) begin
        code_d = in;
        cnt_d  = '0;
      end else if (cnt_q >= dwell) begin
        code_d = N'(code_q + 1'b1);
        cnt_d  = '0;
        wrap_d = (code_q == {N{1'b1}});
      end else begin
        cnt_d = DW'(cnt_q + 1'b1);
      end
      y_d = {{(W-1){1'b0}}, 1'b1} << code_d;
    end

    y_n_d = ~y_d;
  end

  assign y    = y_q;
  assign y_n  = y_n_q;
  assign code = code_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_nx2n.sv
// Directed scoreboard bench for dec_scan_nx2n (N=3, DW=8).
module tb_dec_scan_nx2n;

  logic       clk;
  logic       rst_n;
  logic       en_n;
  logic       mode;
  logic [2:0] in;
  logic [7:0] dwell;
  logic [7:0] y;
  logic [7:0] y_n;
  logic [2:0] code;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] y;
    logic [2:0] code;
    logic       wrap;
  } exp_t;

  exp_t sb[$];

  dec_scan_nx2n #(.N(3), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en_n  (en_n),
    .mode  (mode),
    .in    (in),
    .dwell (dwell),
    .y     (y),
    .y_n   (y_n),
    .code  (code),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: empty queue, nothing to compare");
      return;
    end
    e = sb.pop_front();
    total++;
    assert (y === e.y) else begin
      bad++;
      $error("[TB] FAIL %s y: got %h expected %h", e.tag, y, e.y);
    end
    total++;
    assert (y_n === ~e.y) else begin
      bad++;
      $error("[TB] FAIL %s y_n: got %h expected %h", e.tag, y_n, ~e.y);
    end
    total++;
    assert (code === e.code) else begin
      bad++;
      $error("[TB] FAIL %s code: got %0d expected %0d", e.tag, code, e.code);
    end
    total++;
    assert (wrap === e.wrap) else begin
      bad++;
      $error("[TB] FAIL %s wrap: got %b expected %b", e.tag, wrap, e.wrap);
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the next
  // rising edge, then compare just after that edge.
  task automatic applyStimulus(input string tag, input logic r, input logic e,
                               input logic m, input logic [2:0] i,
                               input logic [7:0] d, input logic on,
                               input logic [2:0] ecode, input logic ewrap);
    exp_t x;
    rst_n = r;
    en_n  = e;
    mode  = m;
    in    = i;
    dwell = d;
    x.tag  = tag;
    x.code = ecode;
    x.y    = on ? (8'd1 << ecode) : 8'h00;
    x.wrap = ewrap;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int wrap_cnt;
    logic [2:0] sc4 [7];
    logic       wr4 [7];
    sc4 = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
    wr4 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; en_n = 1'b0; mode = 1'b0; in = 3'd5; dwell = 8'd0;

    // reset held for two cycles with DIRECT inputs applied
    applyStimulus("reset0", 1'b0, 1'b0, 1'b0, 3'd5, 8'd0, 1'b0, 3'd0, 1'b0);
    applyStimulus("reset1", 1'b0, 1'b0, 1'b0, 3'd5, 8'd0, 1'b0, 3'd0, 1'b0);

    // disabled with X on in
    for (int k = 0; k < 3; k++)
      applyStimulus("idle_x", 1'b1, 1'b1, 1'b0, 3'bxxx, 8'd0, 1'b0, 3'd0, 1'b0);

    // direct sweep of every code
    for (int k = 0; k < 8; k++)
      applyStimulus("direct", 1'b1, 1'b0, 1'b0, 3'(k), 8'd0, 1'b1, 3'(k), 1'b0);

    // scan with dwell=1 starting at 6, crossing the wrap point
    for (int k = 0; k < 7; k++)
      applyStimulus("scan_d1", 1'b1, 1'b0, 1'b1, 3'd6, 8'd1, 1'b1, sc4[k], wr4[k]);

    // one idle cycle: y clears, code holds
    applyStimulus("idle_hold", 1'b1, 1'b1, 1'b1, 3'd4, 8'd0, 1'b0, 3'd1, 1'b0);

    // scan with dwell=0 from 0 for 24 cycles
    wrap_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      applyStimulus("scan_d0", 1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 1'b1, 3'(k % 8),
                    (k % 8 == 0) && (k > 0));
      if (wrap === 1'b1) wrap_cnt++;
    end
    total++;
    assert (wrap_cnt == 2) else begin
      bad++;
      $error("[TB] FAIL wrap_count: got %0d expected 2", wrap_cnt);
    end

    // reset mid-scan at code 3, then restart from in=2
    applyStimulus("scan_e3", 1'b1, 1'b0, 1'b0, 3'd3, 8'd2, 1'b1, 3'd3, 1'b0);
    applyStimulus("scan_e3", 1'b1, 1'b0, 1'b1, 3'd3, 8'd2, 1'b1, 3'd3, 1'b0);
    applyStimulus("mid_rst", 1'b0, 1'b0, 1'b1, 3'd2, 8'd2, 1'b0, 3'd0, 1'b0);
    applyStimulus("restart", 1'b1, 1'b0, 1'b1, 3'd2, 8'd2, 1'b1, 3'd2, 1'b0);
    applyStimulus("dwell2",  1'b1, 1'b0, 1'b1, 3'd7, 8'd2, 1'b1, 3'd2, 1'b0);
    applyStimulus("dwell2",  1'b1, 1'b0, 1'b1, 3'd7, 8'd2, 1'b1, 3'd2, 1'b0);
    applyStimulus("dwell2",  1'b1, 1'b0, 1'b1, 3'd7, 8'd2, 1'b1, 3'd3, 1'b0);

    // dwell raised to 5, cnt climbs to 3, then dwell drops to 0
    for (int k = 0; k < 3; k++)
      applyStimulus("dwell5", 1'b1, 1'b0, 1'b1, 3'd7, 8'd5, 1'b1, 3'd3, 1'b0);
    applyStimulus("dwell_cut", 1'b1, 1'b0, 1'b1, 3'd7, 8'd0, 1'b1, 3'd4, 1'b0);
    applyStimulus("dwell_cut", 1'b1, 1'b0, 1'b1, 3'd7, 8'd0, 1'b1, 3'd5, 1'b0);

    // SCAN -> DIRECT takes effect on the next edge, then disable
    applyStimulus("to_direct", 1'b1, 1'b0, 1'b0, 3'd6, 8'd0, 1'b1, 3'd6, 1'b0);
    applyStimulus("to_idle",   1'b1, 1'b1, 1'b0, 3'd1, 8'd0, 1'b0, 3'd6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
